// File: rtl/dmux8way16_seq_if.sv
// Lane bus for dmux8way16_seq: input word handshake, steering controls, eight registered lanes with per-lane valid/ack.
// The count signal exists only when DMUX8WAY16_COUNT_EN is defined.
interface dmux8way16_seq_if;
    logic [15:0] in;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  sel;
    logic        auto;
    logic [15:0] a, b, c, d, e, f, g, h;
    logic [7:0]  out_valid;
    logic [7:0]  ack;
    logic [2:0]  ptr;
`ifdef DMUX8WAY16_COUNT_EN
    logic [15:0] count;

    modport master (
        output in, in_valid, sel, auto, ack,
        input  in_ready, a, b, c, d, e, f, g, h, out_valid, ptr, count
    );
    modport slave (
        input  in, in_valid, sel, auto, ack,
        output in_ready, a, b, c, d, e, f, g, h, out_valid, ptr, count
    );
`else
    modport master (
        output in, in_valid, sel, auto, ack,
        input  in_ready, a, b, c, d, e, f, g, h, out_valid, ptr
    );
    modport slave (
        input  in, in_valid, sel, auto, ack,
        output in_ready, a, b, c, d, e, f, g, h, out_valid, ptr
    );
`endif
endinterface

// File: rtl/dmux8way16_seq.sv
// Purpose: steer a 16-bit word into one of eight registered lanes, by sel or a round-robin pointer.
// Latency: 1 cycle from acceptance to lane output. Optional transfer counter via DMUX8WAY16_COUNT_EN.
// Backpressure: in_ready drops while the target lane is full and not being acked in the same cycle.
module dmux8way16_seq (
    input  logic             clk,
    input  logic             reset,
    dmux8way16_seq_if.slave  bus
);
    logic [7:0][15:0] lane_q, lane_d;
    logic [7:0]       out_valid_q, out_valid_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [2:0]       target;
    logic             rdy;
    logic             xfer;
`ifdef DMUX8WAY16_COUNT_EN
    logic [15:0]      count_q, count_d;
`endif

    always_comb begin
        target      = bus.auto ? ptr_q : bus.sel;
        rdy         = !out_valid_q[target] | bus.ack[target];
        xfer        = bus.in_valid & rdy;
        lane_d      = lane_q;
        out_valid_d = out_valid_q & ~bus.ack;
        ptr_d       = ptr_q;
        // The write is applied after the ack clear so a same-lane write wins.
        if (xfer) begin
            lane_d[target]      = bus.in;
            out_valid_d[target] = 1'b1;
            if (bus.auto) begin
                ptr_d = ptr_q + 3'd1;
            end
        end
    end

`ifdef DMUX8WAY16_COUNT_EN
    always_comb begin
        count_d = count_q;
        if (xfer) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.count = count_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q      <= '0;
            out_valid_q <= '0;
            ptr_q       <= '0;
        end else begin
            lane_q      <= lane_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = out_valid_q;
    assign bus.ptr       = ptr_q;
    assign bus.a         = lane_q[0];
    assign bus.b         = lane_q[1];
    assign bus.c         = lane_q[2];
    assign bus.d         = lane_q[3];
    assign bus.e         = lane_q[4];
    assign bus.f         = lane_q[5];
    assign bus.g         = lane_q[6];
    assign bus.h         = lane_q[7];
endmodule

// File: tb/tb_dmux8way16_seq.sv
// Directed bench for dmux8way16_seq: the driver pushes hand-computed expectations, a monitor pops and compares.
module tb_dmux8way16_seq;
    logic clk = 1'b0;
    logic reset = 1'b0;

    dmux8way16_seq_if bus ();

    dmux8way16_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           id;
        logic         chk_rdy;
        logic         rdy;
        logic [7:0]   ov;
        logic [2:0]   ptr;
        logic [7:0]   mask;
        logic [127:0] lanes;
        logic         chk_cnt;
        logic [15:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   vec_id = 0;
    logic         g_chk_cnt = 1'b0;
    logic [15:0]  g_cnt     = '0;

    task automatic cmp(input int id, input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL v%0d %s: got %h, expected %h", id, nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge; optionally queue what the DUT must show.
    task automatic vec(input logic rst, input logic [15:0] din, input logic vld, input logic [2:0] s,
                       input logic au, input logic [7:0] ak, input logic crdy, input logic rdy,
                       input logic [7:0] ov, input logic [2:0] p, input logic [7:0] mask,
                       input logic [127:0] lanes, input logic push);
        exp_t e;
        @(negedge clk);
        reset        = rst;
        bus.in       = din;
        bus.in_valid = vld;
        bus.sel      = s;
        bus.auto     = au;
        bus.ack      = ak;
        if (push) begin
            vec_id++;
            e.id      = vec_id;
            e.chk_rdy = crdy;
            e.rdy     = rdy;
            e.ov      = ov;
            e.ptr     = p;
            e.mask    = mask;
            e.lanes   = lanes;
            e.chk_cnt = g_chk_cnt;
            e.cnt     = g_cnt;
            exp_q.push_back(e);
        end
        g_chk_cnt = 1'b0;
    endtask

    // Monitor: in_ready is sampled mid-cycle, registered state just after the edge.
    initial begin
        exp_t e;
        logic rdy_s;
        logic [127:0] act_l;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                rdy_s = bus.in_ready;
                @(posedge clk);
                #1;
                e = exp_q.pop_front();
                n_vec++;
                act_l = {bus.h, bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a};
                if (e.chk_rdy) cmp(e.id, "in_ready", {15'd0, rdy_s}, {15'd0, e.rdy});
                cmp(e.id, "out_valid", {8'd0, bus.out_valid}, {8'd0, e.ov});
                cmp(e.id, "ptr", {13'd0, bus.ptr}, {13'd0, e.ptr});
                for (int i = 0; i < 8; i++) begin
                    if (e.mask[i]) cmp(e.id, $sformatf("lane%0d", i), act_l[16*i +: 16], e.lanes[16*i +: 16]);
                end
`ifdef DMUX8WAY16_COUNT_EN
                if (e.chk_cnt) cmp(e.id, "count", bus.count, e.cnt);
`endif
            end
        end
    end

    initial begin
        bus.in = '0; bus.in_valid = 1'b0; bus.sel = '0; bus.auto = 1'b0; bus.ack = '0;
        // rst din vld sel auto ack | chk rdy ov ptr mask lanes{h..a}
        vec(1, 16'h0, 0, 3'd0, 0, 8'h00, 0, 0, 8'h00, 3'd0, 8'hFF, 128'h0, 1);
        vec(0, 16'h0, 0, 3'd0, 0, 8'h00, 1, 1, 8'h00, 3'd0, 8'hFF, 128'h0, 1);
        // direct write to lane f
        vec(0, 16'h1234, 1, 3'd5, 0, 8'h00, 1, 1, 8'h20, 3'd0, 8'hFF,
            {16'h0, 16'h0, 16'h1234, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 1);
        vec(0, 16'h0, 0, 3'd5, 0, 8'h00, 1, 0, 8'h20, 3'd0, 8'h20, {16'h0, 16'h0, 16'h1234, 80'h0}, 1);
        vec(0, 16'h5555, 1, 3'd5, 0, 8'h00, 1, 0, 8'h20, 3'd0, 8'h20, {16'h0, 16'h0, 16'h1234, 80'h0}, 1);
        // ack and write on the same lane: write wins
        vec(0, 16'hAAAA, 1, 3'd5, 0, 8'h20, 1, 1, 8'h20, 3'd0, 8'h20, {16'h0, 16'h0, 16'hAAAA, 80'h0}, 1);
        vec(0, 16'h0, 0, 3'd5, 0, 8'h20, 1, 1, 8'h00, 3'd0, 8'h20, {16'h0, 16'h0, 16'hAAAA, 80'h0}, 1);
        vec(0, 16'h0, 0, 3'd1, 0, 8'h02, 1, 1, 8'h00, 3'd0, 8'h22, {16'h0, 16'h0, 16'hAAAA, 80'h0}, 1);
        vec(1, 16'h0, 0, 3'd0, 0, 8'h00, 0, 0, 8'h00, 3'd0, 8'hFF, 128'h0, 1);
        // round-robin fill, pointer wraps 7 -> 0
        for (int i = 0; i < 8; i++) begin
            vec(0, 16'(i), 1, 3'd0, 1, 8'h00, 1, 1, 8'((16'h1 << (i + 1)) - 16'h1), 3'(i + 1),
                8'(1 << i), 128'(i) << (16 * i), 1);
        end
        vec(0, 16'h0009, 1, 3'd0, 1, 8'h00, 1, 0, 8'hFF, 3'd0, 8'hFF,
            {16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0}, 1);
        vec(0, 16'h0009, 1, 3'd3, 0, 8'h00, 1, 0, 8'hFF, 3'd0, 8'hFF,
            {16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0}, 1);
        // ack on lane a releases the round-robin target in the same cycle
        vec(0, 16'hBEEF, 1, 3'd3, 1, 8'h01, 1, 1, 8'hFF, 3'd1, 8'hFF,
            {16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'hBEEF}, 1);
        vec(0, 16'h0, 0, 3'd0, 1, 8'hF0, 1, 0, 8'h0F, 3'd1, 8'h0F, {64'h0, 16'd3, 16'd2, 16'd1, 16'hBEEF}, 1);
        vec(0, 16'h0, 0, 3'd0, 1, 8'h05, 1, 0, 8'h0A, 3'd1, 8'h05, {64'h0, 16'd3, 16'd2, 16'd1, 16'hBEEF}, 1);
        vec(0, 16'h7777, 1, 3'd0, 1, 8'h00, 1, 0, 8'h0A, 3'd1, 8'h0F, {64'h0, 16'd3, 16'd2, 16'd1, 16'hBEEF}, 1);
        vec(0, 16'h7777, 1, 3'd0, 0, 8'h00, 1, 1, 8'h0B, 3'd1, 8'h0F, {64'h0, 16'd3, 16'd2, 16'd1, 16'h7777}, 1);
        // reset dominates a simultaneous transfer and ack
        g_chk_cnt = 1'b1; g_cnt = 16'h0000;
        vec(1, 16'h4444, 1, 3'd2, 0, 8'hFF, 0, 0, 8'h00, 3'd0, 8'hFF, 128'h0, 1);
        vec(0, 16'h0, 0, 3'd0, 1, 8'h00, 1, 1, 8'h00, 3'd0, 8'hFF, 128'h0, 1);
`ifdef DMUX8WAY16_COUNT_EN
        for (int k = 0; k < 16'hFFFF; k++) begin
            if (k == 16'hFFFE) begin
                g_chk_cnt = 1'b1; g_cnt = 16'hFFFF;
            end
            vec(0, 16'(k), 1, 3'd0, 0, 8'h01, 1, 1, 8'h01, 3'd0, 8'h01, 128'(k), k == 16'hFFFE);
        end
        g_chk_cnt = 1'b1; g_cnt = 16'h0000;
        vec(0, 16'hCAFE, 1, 3'd0, 0, 8'h01, 1, 1, 8'h01, 3'd0, 8'h01, 128'hCAFE, 1);
`endif
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.ack      = '0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
